// File: rtl/emds_link_scheduler_if.sv
// Requester-side bundle of the link scheduler: level req/data in, ack/grant and framed line out.
// master = requesters (and the bench); slave = the scheduler.
interface emds_link_scheduler_if;
    logic [1:0] req;
    logic [7:0] data_0;
    logic [7:0] data_1;
    logic [1:0] ack;
    logic [1:0] grant;
    logic       serial_out;
    logic       tx_active;
    logic [1:0] msg_done;
    logic       truncated;

    modport master (
        output req, data_0, data_1,
        input  ack, grant, serial_out, tx_active, msg_done, truncated
    );

    modport slave (
        input  req, data_0, data_1,
        output ack, grant, serial_out, tx_active, msg_done, truncated
    );
endinterface

// File: rtl/emds_link_scheduler.sv
// Two-requester serial line scheduler: message-granular round-robin, start/8N LSB-first/stop framing.
// Latency: start bit and ack appear one cycle after the accepting IDLE edge; byte period 11+GAP_CYCLES.
// Backpressure: req/data are held as a level until ack; the owner keeps the line while it has req low.
module emds_link_scheduler #(
    parameter int GAP_CYCLES = 1,
    parameter int MAX_BYTES  = 100
) (
    input  logic                  clock,
    input  logic                  reset_n,
    emds_link_scheduler_if.slave  link
);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, GAP} state_t;

    localparam logic [7:0] GAP_LAST = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;
    localparam logic [8:0] MAX_CNT  = 9'(MAX_BYTES);

    state_t     state, state_d;
    logic [7:0] shreg, shreg_d;
    logic [2:0] bit_cnt, bit_cnt_d;
    logic [7:0] byte_cnt, byte_cnt_d;
    logic [7:0] gap_cnt, gap_cnt_d;
    logic       rr_ptr, rr_d;
    logic [1:0] ack_q, ack_d;
    logic [1:0] grant_q, grant_d;
    logic [1:0] done_q, done_d;
    logic       trunc_q, trunc_d;
    logic       serial_q, serial_d;
    logic       tx_q, tx_d;

    logic       cand;
    logic [2:0] bit_nxt;
    logic [8:0] byte_nxt;

    always_comb begin
        state_d    = state;
        shreg_d    = shreg;
        bit_cnt_d  = bit_cnt;
        byte_cnt_d = byte_cnt;
        gap_cnt_d  = gap_cnt;
        rr_d       = rr_ptr;
        grant_d    = grant_q;
        ack_d      = 2'b00;
        done_d     = 2'b00;
        trunc_d    = 1'b0;
        serial_d   = 1'b1;
        tx_d       = 1'b0;
        bit_nxt    = bit_cnt + 3'd1;
        byte_nxt   = {1'b0, byte_cnt} + 9'd1;

        // An active owner is the only candidate, even while its req is low.
        if (grant_q != 2'b00)
            cand = grant_q[1];
        else if (link.req[rr_ptr])
            cand = rr_ptr;
        else
            cand = ~rr_ptr;

        case (state)
            IDLE: begin
                if (link.req[cand]) begin
                    shreg_d     = cand ? link.data_1 : link.data_0;
                    ack_d[cand] = 1'b1;
                    grant_d     = cand ? 2'b10 : 2'b01;
                    serial_d    = 1'b0;
                    tx_d        = 1'b1;
                    state_d     = START;
                end
            end
            START: begin
                serial_d  = shreg[0];
                tx_d      = 1'b1;
                bit_cnt_d = 3'd0;
                state_d   = DATA;
            end
            DATA: begin
                tx_d = 1'b1;
                if (bit_cnt == 3'd7) begin
                    serial_d = 1'b1;
                    state_d  = STOP;
                end else begin
                    bit_cnt_d = bit_nxt;
                    serial_d  = shreg[bit_nxt];
                end
            end
            STOP: begin
                byte_cnt_d = byte_nxt[7:0];
                gap_cnt_d  = 8'd0;
                state_d    = (GAP_CYCLES > 0) ? GAP : IDLE;
                if (shreg == 8'h00 || byte_nxt >= MAX_CNT) begin
                    done_d     = grant_q;
                    trunc_d    = (shreg != 8'h00);
                    grant_d    = 2'b00;
                    byte_cnt_d = 8'd0;
                    rr_d       = ~grant_q[1];
                end
            end
            GAP: begin
                if (gap_cnt == GAP_LAST)
                    state_d = IDLE;
                else
                    gap_cnt_d = gap_cnt + 8'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            shreg    <= 8'h00;
            bit_cnt  <= 3'd0;
            byte_cnt <= 8'd0;
            gap_cnt  <= 8'd0;
            rr_ptr   <= 1'b0;
            ack_q    <= 2'b00;
            grant_q  <= 2'b00;
            done_q   <= 2'b00;
            trunc_q  <= 1'b0;
            serial_q <= 1'b1;
            tx_q     <= 1'b0;
        end else begin
            state    <= state_d;
            shreg    <= shreg_d;
            bit_cnt  <= bit_cnt_d;
            byte_cnt <= byte_cnt_d;
            gap_cnt  <= gap_cnt_d;
            rr_ptr   <= rr_d;
            ack_q    <= ack_d;
            grant_q  <= grant_d;
            done_q   <= done_d;
            trunc_q  <= trunc_d;
            serial_q <= serial_d;
            tx_q     <= tx_d;
        end
    end

    assign link.ack        = ack_q;
    assign link.grant      = grant_q;
    assign link.msg_done   = done_q;
    assign link.truncated  = trunc_q;
    assign link.serial_out = serial_q;
    assign link.tx_active  = tx_q;

endmodule

// File: tb/tb_emds_link_scheduler.sv
// Directed bench: three scheduler instances (gap 1/limit 100, gap 0/limit 3, gap 2/limit 100)
// driven by requester tasks that check every wire bit, handshakes and message boundaries.
module tb_emds_link_scheduler;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int errs = 0;
    int checks = 0;
    int last_start [3];

    logic [1:0] req_v [3];
    logic [7:0] d0_v  [3];
    logic [7:0] d1_v  [3];
    logic [1:0] ack_w [3];
    logic [1:0] grant_w [3];
    logic [1:0] done_w [3];
    logic       trunc_w [3];
    logic       ser_w [3];
    logic       tx_w [3];

    emds_link_scheduler_if if0 ();
    emds_link_scheduler_if if1 ();
    emds_link_scheduler_if if2 ();

    emds_link_scheduler #(.GAP_CYCLES(1), .MAX_BYTES(100)) dut0 (.clock(clock), .reset_n(reset_n), .link(if0.slave));
    emds_link_scheduler #(.GAP_CYCLES(0), .MAX_BYTES(3))   dut1 (.clock(clock), .reset_n(reset_n), .link(if1.slave));
    emds_link_scheduler #(.GAP_CYCLES(2), .MAX_BYTES(100)) dut2 (.clock(clock), .reset_n(reset_n), .link(if2.slave));

    assign if0.req = req_v[0];  assign if0.data_0 = d0_v[0];  assign if0.data_1 = d1_v[0];
    assign if1.req = req_v[1];  assign if1.data_0 = d0_v[1];  assign if1.data_1 = d1_v[1];
    assign if2.req = req_v[2];  assign if2.data_0 = d0_v[2];  assign if2.data_1 = d1_v[2];

    assign ack_w[0] = if0.ack;   assign grant_w[0] = if0.grant;  assign done_w[0] = if0.msg_done;
    assign ack_w[1] = if1.ack;   assign grant_w[1] = if1.grant;  assign done_w[1] = if1.msg_done;
    assign ack_w[2] = if2.ack;   assign grant_w[2] = if2.grant;  assign done_w[2] = if2.msg_done;
    assign trunc_w[0] = if0.truncated;  assign ser_w[0] = if0.serial_out;  assign tx_w[0] = if0.tx_active;
    assign trunc_w[1] = if1.truncated;  assign ser_w[1] = if1.serial_out;  assign tx_w[1] = if1.tx_active;
    assign trunc_w[2] = if2.truncated;  assign ser_w[2] = if2.serial_out;  assign tx_w[2] = if2.tx_active;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        for (int i = 0; i < 3; i++) begin
            req_v[i] = 2'b00;
            d0_v[i]  = 8'h00;
            d1_v[i]  = 8'h00;
        end
        reset_n = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    // Requester k of instance idx offers byte b; the whole frame and the message-end pulse are checked.
    task automatic send_byte(input int idx, input int k, input logic [7:0] b, input bit keep,
                             input logic [1:0] exp_done, input logic exp_trunc, input int exp_period);
        logic [1:0] oh;
        bit got;
        got = 1'b0;
        oh  = (k == 1) ? 2'b10 : 2'b01;
        if (k == 0) d0_v[idx] = b; else d1_v[idx] = b;
        req_v[idx][k] = 1'b1;
        for (int c = 0; c < 400 && !got; c++) begin
            @(negedge clock);
            if (ack_w[idx] != 2'b00) begin
                got = 1'b1;
                check_eq("ack_who", 32'(ack_w[idx]), 32'(oh));
            end else begin
                check_eq("idle_high", 32'(ser_w[idx]), 32'd1);
            end
        end
        if (!got) begin
            check_eq("ack_timeout", 32'd0, 32'd1);
            return;
        end
        if (exp_period != 0) check_eq("period", 32'(cyc - last_start[idx]), 32'(exp_period));
        last_start[idx] = cyc;
        if (!keep) req_v[idx][k] = 1'b0;
        check_eq("grant", 32'(grant_w[idx]), 32'(oh));
        check_eq("start_bit", 32'(ser_w[idx]), 32'd0);
        check_eq("tx_start", 32'(tx_w[idx]), 32'd1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            check_eq("data_bit", 32'(ser_w[idx]), 32'(b[i]));
            if (i == 0) check_eq("ack_pulse", 32'(ack_w[idx]), 32'd0);
        end
        @(negedge clock);
        check_eq("stop_bit", 32'(ser_w[idx]), 32'd1);
        check_eq("tx_stop", 32'(tx_w[idx]), 32'd1);
        @(negedge clock);
        check_eq("msg_done", 32'(done_w[idx]), 32'(exp_done));
        check_eq("truncated", 32'(trunc_w[idx]), 32'(exp_trunc));
        check_eq("grant_after", 32'(grant_w[idx]), (exp_done != 2'b00) ? 32'd0 : 32'(oh));
        check_eq("post_stop_hi", 32'(ser_w[idx]), 32'd1);
        check_eq("tx_off", 32'(tx_w[idx]), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        bit got;
        for (int i = 0; i < 3; i++) begin
            req_v[i] = 2'b00; d0_v[i] = 8'h00; d1_v[i] = 8'h00; last_start[i] = 0;
        end
        @(negedge clock);
        @(negedge clock);
        check_eq("rst_serial", 32'(ser_w[0]), 32'd1);
        check_eq("rst_ack", 32'(ack_w[0]), 32'd0);
        check_eq("rst_grant", 32'(grant_w[0]), 32'd0);
        check_eq("rst_done", 32'(done_w[0]), 32'd0);
        check_eq("rst_trunc", 32'(trunc_w[0]), 32'd0);
        check_eq("rst_tx", 32'(tx_w[0]), 32'd0);
        reset_n = 1'b1;

        // Single message 0x48 + terminator.
        send_byte(0, 0, 8'h48, 1'b0, 2'b00, 1'b0, 0);
        send_byte(0, 0, 8'h00, 1'b0, 2'b01, 1'b0, 0);

        // Limit of 3 with no terminator while requester 1 waits; gap 0 gives an 11-cycle period.
        req_v[1][1] = 1'b1;
        d1_v[1] = 8'h55;
        send_byte(1, 0, 8'h41, 1'b1, 2'b00, 1'b0, 0);
        send_byte(1, 0, 8'h41, 1'b1, 2'b00, 1'b0, 11);
        send_byte(1, 0, 8'h41, 1'b1, 2'b01, 1'b1, 11);
        req_v[1][0] = 1'b0;
        send_byte(1, 1, 8'h55, 1'b0, 2'b00, 1'b0, 11);
        send_byte(1, 1, 8'h00, 1'b0, 2'b10, 1'b0, 11);

        // Gap of 2 stretches the period to 13.
        send_byte(2, 0, 8'h3C, 1'b1, 2'b00, 1'b0, 0);
        send_byte(2, 0, 8'h00, 1'b0, 2'b01, 1'b0, 13);

        // Contention from reset: requester 0's whole message first, then requester 1.
        do_reset();
        req_v[0] = 2'b11;
        d0_v[0] = 8'h11;
        d1_v[0] = 8'h22;
        send_byte(0, 0, 8'h11, 1'b1, 2'b00, 1'b0, 0);
        send_byte(0, 0, 8'h12, 1'b1, 2'b00, 1'b0, 12);
        send_byte(0, 0, 8'h00, 1'b0, 2'b01, 1'b0, 12);
        send_byte(0, 1, 8'h22, 1'b1, 2'b00, 1'b0, 12);
        send_byte(0, 1, 8'h23, 1'b1, 2'b00, 1'b0, 12);
        send_byte(0, 1, 8'h00, 1'b0, 2'b10, 1'b0, 12);
        req_v[0] = 2'b11;
        d1_v[0] = 8'h00;
        send_byte(0, 0, 8'h00, 1'b0, 2'b01, 1'b0, 0);
        send_byte(0, 1, 8'h00, 1'b0, 2'b10, 1'b0, 12);

        // Owner stalls mid-message; the other requester must not be served.
        send_byte(0, 0, 8'h31, 1'b0, 2'b00, 1'b0, 0);
        req_v[0][1] = 1'b1;
        d1_v[0] = 8'h77;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            check_eq("stall_serial", 32'(ser_w[0]), 32'd1);
            check_eq("stall_grant", 32'(grant_w[0]), 32'd1);
            check_eq("stall_ack", 32'(ack_w[0]), 32'd0);
        end
        send_byte(0, 0, 8'h00, 1'b0, 2'b01, 1'b0, 0);
        send_byte(0, 1, 8'h77, 1'b0, 2'b00, 1'b0, 12);
        send_byte(0, 1, 8'h00, 1'b0, 2'b10, 1'b0, 12);

        // Asynchronous reset during data bit 4, then the held request restarts cleanly.
        req_v[0][0] = 1'b1;
        d0_v[0] = 8'hA5;
        got = 1'b0;
        for (int c = 0; c < 100 && !got; c++) begin
            @(negedge clock);
            if (ack_w[0] != 2'b00) got = 1'b1;
        end
        check_eq("t4_ack_seen", 32'(got), 32'd1);
        repeat (5) @(negedge clock);
        check_eq("t4_bit4", 32'(ser_w[0]), 32'd0);
        #2 reset_n = 1'b0;
        #1;
        check_eq("t4_rst_serial", 32'(ser_w[0]), 32'd1);
        check_eq("t4_rst_tx", 32'(tx_w[0]), 32'd0);
        check_eq("t4_rst_grant", 32'(grant_w[0]), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        send_byte(0, 0, 8'hA5, 1'b0, 2'b00, 1'b0, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
